// File: rtl/aes256_pkg.sv
// AES-256 front-end shared types.
// Job modes, scheduler states and queue entry layout.
package aes256_pkg;

  localparam int BLOCK_W       = 128;
  localparam int NUM_RKEYS_DEF = 15;

  typedef enum logic [1:0] {
    MODE_ENC  = 2'b00,
    MODE_DEC  = 2'b01,
    MODE_SEED = 2'b10,
    MODE_ILL  = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KG_FEED,
    ST_KG_LOAD,
    ST_ENC_RUN,
    ST_DEC_RUN,
    ST_RESP
  } state_e;

  typedef struct packed {
    mode_e              mode;
    logic [BLOCK_W-1:0] data;
  } job_t;

endpackage

// File: rtl/aes256_sync_fifo.sv
// Synchronous FIFO with occupancy count.
// Pointers carry one extra bit to tell full from empty.
module aes256_sync_fifo #(
  parameter int WIDTH = 130,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok;
  logic             pop_ok;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  // Advance pointers on accepted push/pop, wrapping modulo.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, written on accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/aes256_job_scheduler.sv
// AES-256 job scheduler: queues jobs, loads keys,
// dispatches engines and returns results in order.
module aes256_job_scheduler
  import aes256_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_RKEYS  = NUM_RKEYS_DEF
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  in_mode,
  input  logic [127:0]                in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [127:0]                out_data,
  output logic                        out_err,
  output logic                        kg_valid,
  output logic [127:0]                kg_data,
  input  logic                        kg_key_valid,
  output logic                        rom_wr_en,
  output logic [3:0]                  rom_addr,
  output logic                        enc_start,
  output logic                        dec_start,
  output logic [127:0]                eng_data,
  input  logic                        enc_done,
  input  logic                        dec_done,
  input  logic [127:0]                enc_result,
  input  logic [127:0]                dec_result,
  input  logic [3:0]                  enc_key_addr,
  input  logic [3:0]                  dec_key_addr,
  output logic                        key_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam logic [3:0] LAST_KEY = 4'(NUM_RKEYS - 1);

  state_e       state_q, state_d;
  logic [127:0] seed_lo_q, seed_lo_d;
  logic [127:0] seed_hi_q, seed_hi_d;
  logic         seed_half_q, seed_half_d;
  logic         feed_cnt_q, feed_cnt_d;
  logic [3:0]   wr_cnt_q, wr_cnt_d;
  logic         key_valid_q, key_valid_d;
  logic [127:0] out_data_q, out_data_d;
  logic         out_err_q, out_err_d;
  logic [127:0] eng_data_q, eng_data_d;
  logic         enc_start_q, enc_start_d;
  logic         dec_start_q, dec_start_d;

  logic         fifo_pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic [129:0] fifo_rdata;
  job_t         head;

  assign head = job_t'(fifo_rdata);

  aes256_sync_fifo #(
    .WIDTH (130),
    .DEPTH (FIFO_DEPTH)
  ) u_job_q (
    .clk    (clk),
    .resetn (resetn),
    .push   (in_valid),
    .wdata  ({in_mode, in_data}),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign in_ready  = !fifo_full;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign eng_data  = eng_data_q;
  assign enc_start = enc_start_q;
  assign dec_start = dec_start_q;
  assign key_valid = key_valid_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      seed_lo_q   <= '0;
      seed_hi_q   <= '0;
      seed_half_q <= 1'b0;
      feed_cnt_q  <= 1'b0;
      wr_cnt_q    <= '0;
      key_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      eng_data_q  <= '0;
      enc_start_q <= 1'b0;
      dec_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_lo_q   <= seed_lo_d;
      seed_hi_q   <= seed_hi_d;
      seed_half_q <= seed_half_d;
      feed_cnt_q  <= feed_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      key_valid_q <= key_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      eng_data_q  <= eng_data_d;
      enc_start_q <= enc_start_d;
      dec_start_q <= dec_start_d;
    end
  end

  // Next state: pop and decode in IDLE, sequence key load and engines.
  always_comb begin
    state_d     = state_q;
    seed_lo_d   = seed_lo_q;
    seed_hi_d   = seed_hi_q;
    seed_half_d = seed_half_q;
    feed_cnt_d  = feed_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    key_valid_d = key_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    eng_data_d  = eng_data_q;
    enc_start_d = 1'b0;
    dec_start_d = 1'b0;
    fifo_pop    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          unique case (1'b1)
            head.mode == MODE_SEED: begin
              if (!seed_half_q) begin
                seed_lo_d   = head.data;
                key_valid_d = 1'b0;
                seed_half_d = 1'b1;
              end else begin
                seed_hi_d  = head.data;
                feed_cnt_d = 1'b0;
                state_d    = ST_KG_FEED;
              end
            end
            (head.mode == MODE_ENC || head.mode == MODE_DEC)
              && key_valid_q: begin
              eng_data_d = head.data;
              if (head.mode == MODE_ENC) begin
                enc_start_d = 1'b1;
                state_d     = ST_ENC_RUN;
              end else begin
                dec_start_d = 1'b1;
                state_d     = ST_DEC_RUN;
              end
            end
            default: begin
              out_err_d  = 1'b1;
              out_data_d = '0;
              state_d    = ST_RESP;
            end
          endcase
        end
      end
      ST_KG_FEED: begin
        seed_half_d = 1'b0;
        feed_cnt_d  = 1'b1;
        if (feed_cnt_q) begin
          wr_cnt_d = '0;
          state_d  = ST_KG_LOAD;
        end
      end
      ST_KG_LOAD: begin
        if (kg_key_valid) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == LAST_KEY) begin
            key_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_ENC_RUN: begin
        if (enc_done) begin
          out_data_d = enc_result;
          out_err_d  = 1'b0;
          state_d    = ST_RESP;
        end
      end
      ST_DEC_RUN: begin
        if (dec_done) begin
          out_data_d = dec_result;
          out_err_d  = 1'b0;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state: keygen feed, ROM mux, result valid.
  always_comb begin
    kg_valid  = 1'b0;
    kg_data   = '0;
    rom_wr_en = 1'b0;
    rom_addr  = '0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_KG_FEED: begin
        kg_valid = 1'b1;
        kg_data  = feed_cnt_q ? seed_hi_q : seed_lo_q;
      end
      ST_KG_LOAD: begin
        rom_wr_en = kg_key_valid;
        rom_addr  = wr_cnt_q;
      end
      ST_ENC_RUN: rom_addr = enc_key_addr;
      ST_DEC_RUN: rom_addr = dec_key_addr;
      ST_RESP:    out_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes256_job_scheduler.sv
// Directed bench for aes256_job_scheduler.
// Engine models answer 14 cycles after start.
module tb_aes256_job_scheduler;

  localparam logic [127:0] ENC_MASK = {128{1'b1}};
  localparam logic [127:0] DEC_MASK = {64{2'b01}};

  logic         clk;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_mode;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_err;
  logic         kg_valid;
  logic [127:0] kg_data;
  logic         kg_key_valid;
  logic         rom_wr_en;
  logic [3:0]   rom_addr;
  logic         enc_start;
  logic         dec_start;
  logic [127:0] eng_data;
  logic         enc_done;
  logic         dec_done;
  logic [127:0] enc_result;
  logic [127:0] dec_result;
  logic [3:0]   enc_key_addr;
  logic [3:0]   dec_key_addr;
  logic         key_valid;
  logic [3:0]   fifo_count;

  int n_checks;
  int n_errors;
  int n_enc_start;
  int enc_cnt;
  int dec_cnt;

  aes256_job_scheduler dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mode      (in_mode),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_err      (out_err),
    .kg_valid     (kg_valid),
    .kg_data      (kg_data),
    .kg_key_valid (kg_key_valid),
    .rom_wr_en    (rom_wr_en),
    .rom_addr     (rom_addr),
    .enc_start    (enc_start),
    .dec_start    (dec_start),
    .eng_data     (eng_data),
    .enc_done     (enc_done),
    .dec_done     (dec_done),
    .enc_result   (enc_result),
    .dec_result   (dec_result),
    .enc_key_addr (enc_key_addr),
    .dec_key_addr (dec_key_addr),
    .key_valid    (key_valid),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign enc_key_addr = 4'd5;
  assign dec_key_addr = 4'd10;

  // Count encrypt start pulses.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) n_enc_start <= n_enc_start;
    else if (enc_start) n_enc_start <= n_enc_start + 1;
  end

  // Encrypt engine model: result = block ^ ENC_MASK.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      enc_cnt    <= 0;
      enc_done   <= 1'b0;
      enc_result <= '0;
    end else begin
      enc_done <= 1'b0;
      if (enc_start) begin
        enc_cnt    <= 14;
        enc_result <= eng_data ^ ENC_MASK;
      end else if (enc_cnt != 0) begin
        enc_cnt <= enc_cnt - 1;
        if (enc_cnt == 1) enc_done <= 1'b1;
      end
    end
  end

  // Decrypt engine model: result = block ^ DEC_MASK.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dec_cnt    <= 0;
      dec_done   <= 1'b0;
      dec_result <= '0;
    end else begin
      dec_done <= 1'b0;
      if (dec_start) begin
        dec_cnt    <= 14;
        dec_result <= eng_data ^ DEC_MASK;
      end else if (dec_cnt != 0) begin
        dec_cnt <= dec_cnt - 1;
        if (dec_cnt == 1) dec_done <= 1'b1;
      end
    end
  end

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] m,
                      input logic [127:0] d);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 128'(out_valid), 128'd1);
  endtask

  task automatic take_resp(input string tag,
                           input logic err,
                           input logic [127:0] d);
    wait_out(tag);
    check({tag, "_err"}, 128'(out_err), 128'(err));
    check({tag, "_data"}, out_data, d);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_drop"}, 128'(out_valid), 128'd0);
  endtask

  task automatic wait_start(input string tag, input logic enc);
    int n;
    n = 0;
    while (!(enc ? enc_start : dec_start) && n < 20) begin
      step();
      n++;
    end
    check({tag, "_start"},
          128'(enc ? enc_start : dec_start), 128'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},  128'(in_ready),   128'd1);
    check({tag, "_out_valid"}, 128'(out_valid),  128'd0);
    check({tag, "_out_data"},  out_data,         128'd0);
    check({tag, "_out_err"},   128'(out_err),    128'd0);
    check({tag, "_kg_valid"},  128'(kg_valid),   128'd0);
    check({tag, "_kg_data"},   kg_data,          128'd0);
    check({tag, "_rom_wr"},    128'(rom_wr_en),  128'd0);
    check({tag, "_rom_addr"},  128'(rom_addr),   128'd0);
    check({tag, "_enc_start"}, 128'(enc_start),  128'd0);
    check({tag, "_dec_start"}, 128'(dec_start),  128'd0);
    check({tag, "_eng_data"},  eng_data,         128'd0);
    check({tag, "_key_valid"}, 128'(key_valid),  128'd0);
    check({tag, "_count"},     128'(fifo_count), 128'd0);
  endtask

  logic [1:0]   jm [8];
  logic [127:0] jd [8];
  int           idx;
  int           k;
  int           bad;
  int           starts0;
  logic         acc;

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    n_enc_start  = 0;
    resetn       = 1'b0;
    in_valid     = 1'b0;
    in_mode      = 2'b00;
    in_data      = '0;
    out_ready    = 1'b0;
    kg_key_valid = 1'b0;

    jm[0] = 2'b11; jd[0] = 128'h0;
    jm[1] = 2'b00; jd[1] = 128'h0123456789abcdef0123456789abcdef;
    jm[2] = 2'b11; jd[2] = 128'h0;
    jm[3] = 2'b11; jd[3] = 128'h0;
    jm[4] = 2'b00; jd[4] = 128'h1111;
    jm[5] = 2'b00; jd[5] = 128'h2222;
    jm[6] = 2'b00; jd[6] = 128'h3333;
    jm[7] = 2'b00; jd[7] = 128'h4444;

    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    resetn = 1'b1;
    step();

    // Encrypt before any key: error response, no start.
    push(2'b00, 128'h00112233445566778899aabbccddeeff);
    take_resp("nokey", 1'b1, 128'h0);
    check("nokey_nostart", 128'(n_enc_start), 128'd0);

    // Two seed halves, then 15 round-key writes.
    push(2'b10, 128'haaaa_0000_aaaa_0000_aaaa_0000_aaaa_0000);
    push(2'b10, 128'hbbbb_1111_bbbb_1111_bbbb_1111_bbbb_1111);
    check("seed_key_inval", 128'(key_valid), 128'd0);
    k = 0;
    while (!kg_valid && k < 10) begin
      step();
      k++;
    end
    check("kg0_valid", 128'(kg_valid), 128'd1);
    check("kg0_data", kg_data,
          128'haaaa_0000_aaaa_0000_aaaa_0000_aaaa_0000);
    step();
    check("kg1_valid", 128'(kg_valid), 128'd1);
    check("kg1_data", kg_data,
          128'hbbbb_1111_bbbb_1111_bbbb_1111_bbbb_1111);
    step();
    check("kg2_valid", 128'(kg_valid), 128'd0);
    for (int i = 0; i < 15; i++) begin
      kg_key_valid = 1'b1;
      #1;
      check("rom_wr", 128'(rom_wr_en), 128'd1);
      check("rom_wa", 128'(rom_addr), 128'(i));
      if (i == 14) check("key_pre", 128'(key_valid), 128'd0);
      step();
      kg_key_valid = 1'b0;
    end
    check("key_valid", 128'(key_valid), 128'd1);
    check("seed_noout", 128'(out_valid), 128'd0);
    check("seed_rom_wr_idle", 128'(rom_wr_en), 128'd0);

    // Encrypt then decrypt queued back-to-back.
    push(2'b00, 128'h00112233445566778899aabbccddeeff);
    push(2'b01, 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5);
    wait_start("enc_x", 1'b1);
    check("enc_x_eng", eng_data,
          128'h00112233445566778899aabbccddeeff);
    check("enc_x_rom", 128'(rom_addr), 128'd5);
    step();
    check("enc_x_pulse", 128'(enc_start), 128'd0);
    wait_out("enc_x_w");
    check("enc_x_cnt", 128'(fifo_count), 128'd1);
    take_resp("enc_x", 1'b0,
              128'hffeeddccbbaa99887766554433221100);
    wait_start("dec_y", 1'b0);
    check("dec_y_eng", eng_data,
          128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5);
    check("dec_y_rom", 128'(rom_addr), 128'd10);
    take_resp("dec_y", 1'b0,
              128'hf0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0);

    // Stall RESP for 20 cycles while filling the queue.
    push(2'b00, 128'h0);
    wait_out("enc_z_w");
    starts0 = n_enc_start;
    idx = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      k = (idx < 8) ? idx : 7;
      in_valid = (i < 10);
      in_mode  = jm[k];
      in_data  = jd[k];
      acc = in_valid && in_ready;
      if (out_data !== ENC_MASK || !out_valid) bad++;
      step();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("stall_stable", 128'(bad), 128'd0);
    check("stall_nostart", 128'(n_enc_start), 128'(starts0));
    check("full_count", 128'(fifo_count), 128'd8);
    check("full_ready", 128'(in_ready), 128'd0);
    take_resp("enc_z", 1'b0, ENC_MASK);

    // Illegal mode, then encrypt still works.
    take_resp("ill0", 1'b1, 128'h0);
    take_resp("enc_w", 1'b0,
              128'hfedcba9876543210fedcba9876543210);
    take_resp("ill2", 1'b1, 128'h0);
    take_resp("ill3", 1'b1, 128'h0);

    // Reset during ENC_RUN with three jobs queued.
    wait_start("enc_v", 1'b1);
    check("enc_v_eng", eng_data, 128'h1111);
    check("enc_v_cnt", 128'(fifo_count), 128'd3);
    repeat (3) step();
    check("enc_v_rom", 128'(rom_addr), 128'd5);
    resetn = 1'b0;
    #1;
    check_reset("midrst");
    step();
    resetn = 1'b1;
    repeat (3) step();
    check("post_out_valid", 128'(out_valid), 128'd0);
    check("post_count", 128'(fifo_count), 128'd0);
    check("post_key", 128'(key_valid), 128'd0);
    check("post_start", 128'(enc_start), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes256_job_scheduler.md
# aes256_job_scheduler

Front-end controller for the AES-256 device: it accepts jobs (encrypt, decrypt, key seed) on a valid/ready stream and queues them in order. It sequences the key generator to fill the round-key ROM, dispatches blocks to the encrypter or decrypter, and arbitrates ROM address ownership between the key loader and the two engines. Results leave on a valid/ready stream in job order. It sits between the AXI-facing shell and the enc/dec/keygen/romKey instances.

## Interface
- FIFO_DEPTH, 8, job queue entries (power of 2, ≥2)
- NUM_RKEYS, 15, round keys written to ROM per key load (≤16)
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- in_valid / in_ready  in / out  1 / 1  job handshake
- in_mode  in  2  00 enc, 01 dec, 10 seed half, 11 illegal
- in_data  in  128  plaintext, ciphertext or seed half
- out_valid / out_ready  out / in  1 / 1  result handshake
- out_data  out  128  result block
- out_err  out  1  result is an error response
- kg_valid  out  1  seed half valid to keygen
- kg_data  out  128  seed half
- kg_key_valid  in  1  keygen round-key strobe, one per key
- rom_wr_en  out  1  ROM write strobe
- rom_addr  out  4  ROM address (muxed)
- enc_start / dec_start  out  1 / 1  one-cycle start pulse
- eng_data  out  128  block to engine, held until done
- enc_done / dec_done  in  1 / 1  engine completion pulse
- enc_result / dec_result  in  128 / 128  engine output
- enc_key_addr / dec_key_addr  in  4 / 4  engine ROM address requests
- key_valid  out  1  full key schedule present in ROM
- fifo_count  out  $clog2(FIFO_DEPTH)+1  queued jobs

## Operation
- Queue: 130-bit entries {mode, data}. in_ready = !full. Push on in_valid&&in_ready. Pop only in IDLE, when non-empty.
- FSM states: IDLE, KG_FEED, KG_LOAD, ENC_RUN, DEC_RUN, RESP.
- IDLE pop by mode:
  - Seed, first half (seed_half=0): latch into seed_lo, clear key_valid, set seed_half=1, stay IDLE. No output.
  - Seed, second half: latch into seed_hi, go to KG_FEED.
  - Enc/dec with key_valid=1: present eng_data, pulse enc_start/dec_start, go to ENC_RUN/DEC_RUN.
  - Enc/dec with key_valid=0: out_err=1, out_data=0, go to RESP.
  - Mode 11: out_err=1, out_data=0, go to RESP.
- KG_FEED: kg_valid=1 for exactly two cycles, seed_lo then seed_hi. Clear seed_half. Go to KG_LOAD with wr_cnt=0.
- KG_LOAD: on each kg_key_valid, rom_wr_en=1 (same cycle), rom_addr=wr_cnt, wr_cnt++. The write at wr_cnt=NUM_RKEYS-1 sets key_valid=1 and returns to IDLE. Seeds produce no result.
- ENC_RUN/DEC_RUN: rom_addr = enc_key_addr/dec_key_addr. On the matching done, register the result into out_data with out_err=0 and go to RESP. A done from the other engine is ignored.
- rom_addr = 0 in IDLE, KG_FEED and RESP. rom_wr_en=1 only in KG_LOAD.
- RESP: out_valid=1, out_data/out_err stable until out_ready. Go to IDLE on the handshake cycle.
- A seed half while key load is pending is impossible: the queue is not popped outside IDLE.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_err=0, kg_valid=0, kg_data=0, rom_wr_en=0, rom_addr=0, enc_start=0, dec_start=0, eng_data=0, key_valid=0, fifo_count=0. State=IDLE, seed_half=0.
- Reset mid-operation aborts the job, empties the queue and invalidates the key.
- Push to earliest pop: 1 cycle (registered queue). Start pulse is registered, issued the cycle after the pop.
- Done to out_valid: 1 cycle. Back-to-back jobs: at least 1 IDLE cycle between RESP and the next start.
- Full queue: in_ready=0, and a push attempt is not accepted.
- Pop and push in the same cycle are both accepted; fifo_count is unchanged.
- Pointer wrap at FIFO_DEPTH is modulo. full/empty are distinguished by the extra count bit.

## Structure
- aes256_pkg holds:
  - the mode enum (MODE_ENC, MODE_DEC, MODE_SEED, MODE_ILL)
  - the FSM state enum
  - NUM_RKEYS_DEF = 15
  - BLOCK_W = 128
- Sub-module aes256_sync_fifo: parameterised width/depth, count output, used for the job queue.

## Test plan
- Seed A then B, keygen model strobes 15 keys -> two kg_valid cycles (A then B); rom_wr_en at addresses 0..14; key_valid rises after the write to address 14; no out_valid.
- Enc 0x00112233…ff before any seed -> out_valid with out_err=1, out_data=0; enc_start never pulses.
- After key load, enc X then dec Y queued back-to-back, engine models done at 14 cycles -> results in order; rom_addr follows enc_key_addr, then dec_key_addr.
- Hold out_ready=0 for 20 cycles during RESP -> out_data stable; no new start; the queue keeps accepting until fifo_count=8, then in_ready=0.
- Mode 11 job -> out_err=1 response; the following enc job still processes normally.
- Assert resetn low during ENC_RUN with 3 jobs queued -> all outputs return to reset values; key_valid=0; fifo_count=0.
